// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares the SPI slave transmit sink between NUM_REQ requesters.
// Arbitration is round-robin and holds the grant for a whole packet. Each beat
// is tagged with channel CHANNEL_BASE + requester index. A one-beat output
// register drives the sink.
// Optional feature macro: SPI_ARB_TIMEOUT_EN. When defined, a lock held for
// TIMEOUT_CYCLES cycles without a transfer is force-released.
module spi_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CHANNEL_BASE   = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    sink_valid,
  output logic [15:0]             sink_data,
  output logic [7:0]              sink_channel,
  input  logic                    sink_ready,
  output logic                    busy,
  output logic [2:0]              grant_idx,
  output logic                    timeout_pulse
);

  // Parameter sanity checks at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gBadNumReq
    $error("spi_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (CHANNEL_BASE < 0 || CHANNEL_BASE + NUM_REQ - 1 > 255) begin : gBadChannel
    $error("spi_tx_arbiter: channel range exceeds 0..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("spi_tx_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lockState_e;

  lockState_e  state_q, state_d;
  logic [2:0]  lockIdx_q, lockIdx_d;
  logic [2:0]  rrPtr_q, rrPtr_d;
  logic [2:0]  grantIdx_q, grantIdx_d;
  logic        sinkValid_q, sinkValid_d;
  logic [15:0] sinkData_q, sinkData_d;
  logic [7:0]  sinkChannel_q, sinkChannel_d;

  // Inputs padded to eight requesters so a 3-bit index always fits exactly.
  logic [7:0]   validPad;
  logic [7:0]   lastPad;
  logic [127:0] dataPad;
  logic [7:0]   readyPad;

  logic        loadEn;
  logic        pickValid;
  logic [2:0]  pick;
  logic        xfer;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] stallCnt_q, stallCnt_d;
  logic        timeoutPulse_q, timeoutPulse_d;
`endif

  assign validPad = 8'(req_valid);
  assign lastPad  = 8'(req_last);
  assign dataPad  = 128'(req_data);

  function automatic logic [2:0] nextIdx(input logic [2:0] idx);
    return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Choose which requester may be offered ready: the lock owner, or the first
  // valid requester at or after the round-robin pointer.
  always_comb begin
    logic [2:0] candidate;
    candidate = 3'd0;
    pick      = lockIdx_q;
    pickValid = 1'b0;
    if (state_q == ST_LOCKED) begin
      pickValid = 1'b1;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        candidate = 3'((int'(rrPtr_q) + k) % NUM_REQ);
        if (validPad[candidate]) begin
          pick      = candidate;
          pickValid = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the picked requester and only when the output register can load.
  always_comb begin
    loadEn   = !sinkValid_q || sink_ready;
    readyPad = 8'd0;
    if (pickValid && loadEn) begin
      readyPad[pick] = 1'b1;
    end
    req_ready = readyPad[NUM_REQ-1:0];
    xfer      = pickValid && loadEn && validPad[pick];
  end

  // Next-state for the lock FSM, round-robin pointer and output register.
  always_comb begin
    state_d       = state_q;
    lockIdx_d     = lockIdx_q;
    rrPtr_d       = rrPtr_q;
    grantIdx_d    = grantIdx_q;
    sinkValid_d   = sinkValid_q;
    sinkData_d    = sinkData_q;
    sinkChannel_d = sinkChannel_q;
`ifdef SPI_ARB_TIMEOUT_EN
    stallCnt_d     = 16'd0;
    timeoutPulse_d = 1'b0;
`endif
    if (xfer) begin
      sinkValid_d   = 1'b1;
      sinkData_d    = dataPad[{pick, 4'b0000} +: 16];
      sinkChannel_d = 8'(CHANNEL_BASE) + {5'd0, pick};
      grantIdx_d    = pick;
      if (lastPad[pick]) begin
        state_d = ST_OPEN;
        rrPtr_d = nextIdx(pick);
      end else begin
        state_d   = ST_LOCKED;
        lockIdx_d = pick;
      end
    end else begin
      if (loadEn) begin
        sinkValid_d = 1'b0;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      if (state_q == ST_LOCKED) begin
        if (stallCnt_q + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
          state_d        = ST_OPEN;
          rrPtr_d        = nextIdx(lockIdx_q);
          timeoutPulse_d = 1'b1;
        end else begin
          stallCnt_d = stallCnt_q + 16'd1;
        end
      end
`endif
    end
  end

  // State registers; reset drops any lock and discards the output beat.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= ST_OPEN;
      lockIdx_q     <= 3'd0;
      rrPtr_q       <= 3'd0;
      grantIdx_q    <= 3'd0;
      sinkValid_q   <= 1'b0;
      sinkData_q    <= 16'd0;
      sinkChannel_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      lockIdx_q     <= lockIdx_d;
      rrPtr_q       <= rrPtr_d;
      grantIdx_q    <= grantIdx_d;
      sinkValid_q   <= sinkValid_d;
      sinkData_q    <= sinkData_d;
      sinkChannel_q <= sinkChannel_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Stall counter and the one-cycle force-release pulse.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stallCnt_q     <= 16'd0;
      timeoutPulse_q <= 1'b0;
    end else begin
      stallCnt_q     <= stallCnt_d;
      timeoutPulse_q <= timeoutPulse_d;
    end
  end
  assign timeout_pulse = timeoutPulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign sink_valid   = sinkValid_q;
  assign sink_data    = sinkData_q;
  assign sink_channel = sinkChannel_q;
  assign grant_idx    = grantIdx_q;
  assign busy         = (state_q == ST_LOCKED) || sinkValid_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Testbench for spi_tx_arbiter: directed packet scenarios with a transaction
// level reference model checked on every falling clock edge.
module tb_spi_tx_arbiter;

  localparam int N  = 4;
  localparam int CB = 16;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    reqValid = '0;
  logic [N-1:0]    reqLast = '0;
  logic [16*N-1:0] reqData = '0;
  logic            sinkReady = 1'b1;
  logic [N-1:0]    reqReady;
  logic            sinkValid;
  logic [15:0]     sinkData;
  logic [7:0]      sinkChannel;
  logic            busy;
  logic [2:0]      grantIdx;
  logic            timeoutPulse;

  logic            tbSinkReady = 1'b1;
  logic [16:0]     beatQ [N][$];
  logic [N-1:0]    acceptVec;
  int              compared = 0;
  int              mismatched = 0;
  int              expChan [12] = '{18, 19, 16, 17, 18, 19, 16, 17, 18, 19, 16, 17};

  // Reference model state: the output beat, lock owner and round-robin pointer.
  bit          mValid = 0;
  logic [15:0] mData = '0;
  logic [7:0]  mChan = '0;
  int          mGrant = 0;
  int          mPtr = 0;
  int          mOwner = 0;
  bit          mLocked = 0;
  int          mStall = 0;
  bit          mPulse = 0;
  logic [N-1:0] er;
  int          winner;
  bit          mXfer;

  spi_tx_arbiter #(
    .NUM_REQ(N),
    .CHANNEL_BASE(CB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_clk(clock),
    .reset_reset(reset),
    .req_valid(reqValid),
    .req_data(reqData),
    .req_last(reqLast),
    .req_ready(reqReady),
    .sink_valid(sinkValid),
    .sink_data(sinkData),
    .sink_channel(sinkChannel),
    .sink_ready(sinkReady),
    .busy(busy),
    .grant_idx(grantIdx),
    .timeout_pulse(timeoutPulse)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance whole cycles: note which beats were accepted, then present queue heads.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(negedge clock);
      acceptVec = reqValid & reqReady;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acceptVec[i] && beatQ[i].size() > 0) void'(beatQ[i].pop_front());
        if (beatQ[i].size() > 0) begin
          reqValid[i]          = 1'b1;
          reqData[16*i +: 16]  = beatQ[i][0][15:0];
          reqLast[i]           = beatQ[i][0][16];
        end else begin
          reqValid[i] = 1'b0;
          reqLast[i]  = 1'b0;
        end
      end
      sinkReady = tbSinkReady;
    end
  endtask

  // Who the rules say may receive ready right now.
  function automatic logic [N-1:0] expectedReady();
    logic [N-1:0] r;
    int idx;
    r = '0;
    if (mValid && !sinkReady) return r;
    if (mLocked) begin
      r[mOwner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      idx = (mPtr + k) % N;
      if (reqValid[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Compare DUT outputs with the model every cycle, then advance the model.
  always @(negedge clock) begin
    if (reset) begin
      mValid = 0; mData = '0; mChan = '0; mGrant = 0; mPtr = 0;
      mOwner = 0; mLocked = 0; mStall = 0; mPulse = 0;
    end
    er = expectedReady();
    checkOutput("req_ready", 32'(reqReady), 32'(er));
    checkOutput("sink_valid", 32'(sinkValid), 32'(mValid));
    if (mValid) begin
      checkOutput("sink_data", 32'(sinkData), 32'(mData));
      checkOutput("sink_channel", 32'(sinkChannel), 32'(mChan));
    end
    checkOutput("busy", 32'(busy), 32'(mLocked || mValid));
    checkOutput("grant_idx", 32'(grantIdx), 32'(mGrant));
    checkOutput("timeout_pulse", 32'(timeoutPulse), 32'(mPulse));
    if (!reset) begin
      mXfer  = 0;
      winner = 0;
      for (int i = 0; i < N; i++) begin
        if (er[i] && reqValid[i]) begin
          mXfer  = 1;
          winner = i;
        end
      end
      mPulse = 0;
      if (mXfer) begin
        mValid = 1;
        mData  = reqData[16*winner +: 16];
        mChan  = 8'(CB + winner);
        mGrant = winner;
        mStall = 0;
        if (reqLast[winner]) begin
          mLocked = 0;
          mPtr    = (winner + 1) % N;
        end else begin
          mLocked = 1;
          mOwner  = winner;
        end
      end else begin
        if (!mValid || sinkReady) mValid = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        if (mLocked) begin
          mStall++;
          if (mStall == TO) begin
            mLocked = 0;
            mPtr    = (mOwner + 1) % N;
            mStall  = 0;
            mPulse  = 1;
          end
        end
`endif
      end
    end
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while reset is held.
    applyStimulus(2);
    #2;
    checkOutput("rst sink_valid", 32'(sinkValid), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst grant_idx", 32'(grantIdx), 32'd0);
    checkOutput("rst req_ready", 32'(reqReady), 32'd0);
    checkOutput("rst timeout_pulse", 32'(timeoutPulse), 32'd0);
    reset = 1'b0;

    // Single beat from requester 1.
    beatQ[1].push_back({1'b1, 16'hA5A5});
    applyStimulus(2);
    #2;
    checkOutput("t1 sink_valid", 32'(sinkValid), 32'd1);
    checkOutput("t1 sink_data", 32'(sinkData), 32'hA5A5);
    checkOutput("t1 sink_channel", 32'(sinkChannel), 32'h11);
    checkOutput("t1 grant_idx", 32'(grantIdx), 32'd1);

    // All four requesters stream single-beat packets; pointer starts at 2.
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 3; n++)
        beatQ[i].push_back({1'b1, 16'((i << 12) | n)});
    applyStimulus(1);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1);
      #2;
      checkOutput("t2 sink_valid", 32'(sinkValid), 32'd1);
      checkOutput("t2 sink_channel", 32'(sinkChannel), 32'(expChan[k]));
    end

    // Three-beat packet from requester 0 while requester 2 waits.
    beatQ[0].push_back({1'b0, 16'h0001});
    beatQ[0].push_back({1'b0, 16'h0002});
    beatQ[0].push_back({1'b1, 16'h0003});
    applyStimulus(1);
    beatQ[2].push_back({1'b1, 16'h2222});
    applyStimulus(1);
    #2;
    checkOutput("t3 beat1", 32'(sinkData), 32'h0001);
    checkOutput("t3 locked ready", 32'(reqReady), 32'b0001);
    applyStimulus(1);
    #2;
    checkOutput("t3 beat2", 32'(sinkData), 32'h0002);
    checkOutput("t3 locked ready2", 32'(reqReady), 32'b0001);
    applyStimulus(1);
    #2;
    checkOutput("t3 beat3", 32'(sinkData), 32'h0003);
    checkOutput("t3 beat3 channel", 32'(sinkChannel), 32'h10);
    checkOutput("t3 release ready", 32'(reqReady), 32'b0100);

    // Sink stalls for five cycles with the output register full.
    tbSinkReady = 1'b0;
    beatQ[1].push_back({1'b1, 16'hB001});
    beatQ[1].push_back({1'b1, 16'hB002});
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      #2;
      checkOutput("t4 held data", 32'(sinkData), 32'h2222);
      checkOutput("t4 held ready", 32'(reqReady), 32'd0);
    end
    tbSinkReady = 1'b1;
    applyStimulus(1);
    #2;
    checkOutput("t4 release ready", 32'(reqReady), 32'b0010);
    applyStimulus(1);
    #2;
    checkOutput("t4 next beat", 32'(sinkData), 32'hB001);
    applyStimulus(1);
    #2;
    checkOutput("t4 following beat", 32'(sinkData), 32'hB002);

    // Requester 3 locks with a non-last beat and goes quiet; requester 0 waits.
    beatQ[3].push_back({1'b0, 16'h3333});
    applyStimulus(1);
    beatQ[0].push_back({1'b1, 16'h0AAA});
    applyStimulus(1);
    #2;
    checkOutput("t5 lock channel", 32'(sinkChannel), 32'h13);
    checkOutput("t5 lock ready", 32'(reqReady), 32'b1000);
`ifdef SPI_ARB_TIMEOUT_EN
    applyStimulus(7);
    #2;
    checkOutput("t5 pulse before", 32'(timeoutPulse), 32'd0);
    applyStimulus(1);
    #2;
    checkOutput("t5 pulse", 32'(timeoutPulse), 32'd1);
    checkOutput("t5 ready after release", 32'(reqReady), 32'b0001);
    applyStimulus(1);
    #2;
    checkOutput("t5 pulse after", 32'(timeoutPulse), 32'd0);
    checkOutput("t5 req0 channel", 32'(sinkChannel), 32'h10);
`else
    applyStimulus(10);
    #2;
    checkOutput("t5 lock held", 32'(reqReady), 32'b1000);
    checkOutput("t5 no pulse", 32'(timeoutPulse), 32'd0);
    checkOutput("t5 busy held", 32'(busy), 32'd1);
    beatQ[3].push_back({1'b1, 16'h3334});
    applyStimulus(2);
    #2;
    checkOutput("t5 last beat", 32'(sinkData), 32'h3334);
    checkOutput("t5 ready after release", 32'(reqReady), 32'b0001);
    applyStimulus(1);
    #2;
    checkOutput("t5 req0 channel", 32'(sinkChannel), 32'h10);
`endif

    // Reset while requester 2 holds the lock mid-packet.
    beatQ[2].push_back({1'b0, 16'h5555});
    applyStimulus(2);
    #2;
    checkOutput("t6 locked busy", 32'(busy), 32'd1);
    checkOutput("t6 locked grant", 32'(grantIdx), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("t6 reset sink_valid", 32'(sinkValid), 32'd0);
    checkOutput("t6 reset busy", 32'(busy), 32'd0);
    applyStimulus(2);
    reset = 1'b0;
    beatQ[1].push_back({1'b1, 16'h1111});
    beatQ[2].push_back({1'b1, 16'h2221});
    applyStimulus(2);
    #2;
    checkOutput("t6 first channel", 32'(sinkChannel), 32'h11);
    applyStimulus(1);
    #2;
    checkOutput("t6 second channel", 32'(sinkChannel), 32'h12);
    applyStimulus(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
